parity_checker: RTL and testbench

- Serial receive-side companion to the team's serial parity generator.
- Accepts a bit stream framed as DATA_BITS data bits followed by one parity bit, with the first bit received stored as bit 0 (LSB first).
- Reassembles each data word, checks its parity and emits the word with a one-cycle valid/error pulse.
- Sits at the receive end of the serial parity link, feeding downstream word-level logic.

---
 rtl/parity_pkg.sv | 22 ++
 rtl/serial_shift_reg.sv | 34 +++
 rtl/parity_checker.sv | 160 ++++++++++++++++
 tb/tb_parity_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the serial parity link (generator and checker).
// Holds the receive FSM state encodings, the parity-sense constants and a
// helper that folds the running parity with the parity bit.
package parity_pkg;

    typedef enum logic [0:0] {
        S_DATA = 1'b0,
        S_PAR  = 1'b1
    } state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Error flag for a completed frame: with even sense the XOR of all data
    // bits and the parity bit must be 0; with odd sense it must be 1.
    function automatic logic parity_mismatch(input logic running,
                                             input logic par_bit,
                                             input logic sense);
        return running ^ par_bit ^ sense;
    endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Serial-in / parallel-out register written one bit at a time by index.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear of the whole word (wins over load)
//   load  - write d into bit position idx
//   idx   - bit position to write
//   d     - serial data bit
//   q     - assembled parallel word
module serial_shift_reg #(
    parameter int W     = 3,
    parameter int IDX_W = $clog2(W)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [IDX_W-1:0] idx,
    input  logic             d,
    output logic [W-1:0]     q
);

    logic [W-1:0] word_r;

    // Word register: clear, or drop the incoming bit into its slot.
    always_ff @(posedge clk) begin
        if (clr) begin
            word_r <= {W{1'b0}};
        end else if (load) begin
            word_r[idx] <= d;
        end
    end

    assign q = word_r;

endmodule

// File: rtl/parity_checker.sv
// Receive-side serial parity checker. Collects DATA_BITS data bits (first bit
// received lands in bit 0) followed by one parity bit, then presents the word
// with a one-cycle data_valid pulse and its parity_err flag.
// Optional macro PARITY_ERR_CNT_EN adds a saturating parity error counter.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   w_valid    - qualifies w
//   w          - serial data/parity bit
//   data_out   - last completed data word (held between pulses)
//   data_valid - one-cycle pulse when data_out/parity_err update
//   parity_err - parity mismatch of the frame just completed
//   busy       - a frame is partially received
//   err_count  - saturating error count (PARITY_ERR_CNT_EN only)
module parity_checker
    import parity_pkg::*;
#(
    parameter int DATA_BITS  = 3,
    parameter int ODD_PARITY = 0,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 w_valid,
    input  logic                 w,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 busy
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_count
`else
    // no error counter port in this build
`endif
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic SENSE = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    if (DATA_BITS < 2 || DATA_BITS > 32 || ERR_CNT_W < 1) begin : g_bad_param
        $error("parity_checker: illegal DATA_BITS or ERR_CNT_W");
    end

    state_t               state_r, state_nxt_s;
    logic [IDX_W-1:0]     bit_cnt_r, bit_cnt_nxt_s;
    logic                 running_r, running_nxt_s;
    logic [DATA_BITS-1:0] data_out_r, data_out_nxt_s;
    logic                 parity_err_r, parity_err_nxt_s;
    logic                 data_valid_r, data_valid_nxt_s;
    logic                 busy_r, busy_nxt_s;
    logic                 load_s;
    logic [DATA_BITS-1:0] word_s;

    serial_shift_reg #(
        .W     (DATA_BITS),
        .IDX_W (IDX_W)
    ) u_sreg (
        .clk  (clk),
        .clr  (rst),
        .load (load_s),
        .idx  (bit_cnt_r),
        .d    (w),
        .q    (word_s)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_DATA;
            bit_cnt_r    <= {IDX_W{1'b0}};
            running_r    <= 1'b0;
            data_out_r   <= {DATA_BITS{1'b0}};
            parity_err_r <= 1'b0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            bit_cnt_r    <= bit_cnt_nxt_s;
            running_r    <= running_nxt_s;
            data_out_r   <= data_out_nxt_s;
            parity_err_r <= parity_err_nxt_s;
            data_valid_r <= data_valid_nxt_s;
            busy_r       <= busy_nxt_s;
        end
    end

    // Next-state logic: gather data bits, then judge the parity bit.
    always_comb begin
        state_nxt_s      = state_r;
        bit_cnt_nxt_s    = bit_cnt_r;
        running_nxt_s    = running_r;
        data_out_nxt_s   = data_out_r;
        parity_err_nxt_s = parity_err_r;
        data_valid_nxt_s = 1'b0;
        load_s           = 1'b0;
        case (state_r)
            S_DATA: begin
                if (w_valid) begin
                    load_s        = 1'b1;
                    running_nxt_s = running_r ^ w;
                    if (bit_cnt_r == LAST_IDX) begin
                        bit_cnt_nxt_s = {IDX_W{1'b0}};
                        state_nxt_s   = S_PAR;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_PAR: begin
                if (w_valid) begin
                    state_nxt_s      = S_DATA;
                    running_nxt_s    = 1'b0;
                    data_out_nxt_s   = word_s;
                    parity_err_nxt_s = parity_mismatch(running_r, w, SENSE);
                    data_valid_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s   = S_DATA;
                bit_cnt_nxt_s = {IDX_W{1'b0}};
                running_nxt_s = 1'b0;
            end
        endcase
        // busy is registered from the next state so it tracks the state
        // register exactly, with no path from w/w_valid to the pin.
        busy_nxt_s = (state_nxt_s == S_PAR) || (bit_cnt_nxt_s != {IDX_W{1'b0}});
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign parity_err = parity_err_r;
    assign busy       = busy_r;

`ifdef PARITY_ERR_CNT_EN
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};

    logic [ERR_CNT_W-1:0] err_count_r;

    // Error counter, updated on the same edge that raises the flagged pulse
    // so err_count already includes the frame while data_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r <= {ERR_CNT_W{1'b0}};
        end else if (data_valid_nxt_s && parity_err_nxt_s && (err_count_r != CNT_MAX)) begin
            err_count_r <= err_count_r + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_count_r;
`else
    // counter logic absent in this build
`endif

endmodule

// File: tb/tb_parity_checker.sv
// Directed bench for parity_checker. Two instances share the serial input:
// one even-parity (defaults), one odd-parity with a 2-bit error counter.
// Expected words/flags are pushed per frame and popped on each data_valid.
module tb_parity_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       w_valid = 1'b0;
    logic       w = 1'b0;

    logic [2:0] data_out_e, data_out_o;
    logic       data_valid_e, data_valid_o;
    logic       parity_err_e, parity_err_o;
    logic       busy_e, busy_o;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_count_e;
    logic [1:0] err_count_o;
    int         exp_cnt_e = 0;
    int         exp_cnt_o = 0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulses_e = 0;
    logic [3:0] q_e[$];
    logic [3:0] q_o[$];
    int         times_e[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    parity_checker #(.DATA_BITS(3), .ODD_PARITY(0), .ERR_CNT_W(8)) dut_even (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w(w),
        .data_out(data_out_e), .data_valid(data_valid_e),
        .parity_err(parity_err_e), .busy(busy_e)
`ifdef PARITY_ERR_CNT_EN
        , .err_count(err_count_e)
`endif
    );

    parity_checker #(.DATA_BITS(3), .ODD_PARITY(1), .ERR_CNT_W(2)) dut_odd (
        .clk(clk), .rst(rst), .w_valid(w_valid), .w(w),
        .data_out(data_out_o), .data_valid(data_valid_o),
        .parity_err(parity_err_o), .busy(busy_o)
`ifdef PARITY_ERR_CNT_EN
        , .err_count(err_count_o)
`endif
    );

    // Scoreboard for the even-parity instance.
    always @(negedge clk) begin
        logic [3:0] exp;
        if (data_valid_e === 1'b1) begin
            pulses_e++;
            times_e.push_back(cyc);
            checks++;
            assert (q_e.size() > 0) else begin
                failures++; $error("FAIL even_unexpected_pulse observed=1 expected=0");
            end
            if (q_e.size() > 0) begin
                exp = q_e.pop_front();
                checks++;
                assert (data_out_e === exp[2:0]) else begin
                    failures++; $error("FAIL even_data observed=%b expected=%b", data_out_e, exp[2:0]);
                end
                checks++;
                assert (parity_err_e === exp[3]) else begin
                    failures++; $error("FAIL even_perr observed=%b expected=%b", parity_err_e, exp[3]);
                end
                checks++;
                assert (busy_e === 1'b0) else begin
                    failures++; $error("FAIL even_busy_at_pulse observed=%b expected=0", busy_e);
                end
`ifdef PARITY_ERR_CNT_EN
                if (exp[3] && exp_cnt_e < 255) exp_cnt_e++;
                checks++;
                assert (int'(err_count_e) == exp_cnt_e) else begin
                    failures++; $error("FAIL even_errcnt observed=%0d expected=%0d", err_count_e, exp_cnt_e);
                end
`endif
            end
        end
    end

    // Scoreboard for the odd-parity instance.
    always @(negedge clk) begin
        logic [3:0] exp;
        if (data_valid_o === 1'b1) begin
            checks++;
            assert (q_o.size() > 0) else begin
                failures++; $error("FAIL odd_unexpected_pulse observed=1 expected=0");
            end
            if (q_o.size() > 0) begin
                exp = q_o.pop_front();
                checks++;
                assert (data_out_o === exp[2:0]) else begin
                    failures++; $error("FAIL odd_data observed=%b expected=%b", data_out_o, exp[2:0]);
                end
                checks++;
                assert (parity_err_o === exp[3]) else begin
                    failures++; $error("FAIL odd_perr observed=%b expected=%b", parity_err_o, exp[3]);
                end
`ifdef PARITY_ERR_CNT_EN
                if (exp[3] && exp_cnt_o < 3) exp_cnt_o++;
                checks++;
                assert (int'(err_count_o) == exp_cnt_o) else begin
                    failures++; $error("FAIL odd_errcnt observed=%0d expected=%0d", err_count_o, exp_cnt_o);
                end
`endif
            end
        end
    end

    task automatic send_bit(input logic b);
        @(negedge clk);
        w_valid = 1'b1;
        w = b;
    endtask

    task automatic idle(input int n, input bit chk_busy);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w_valid = 1'b0;
            w = 1'b0;
            if (chk_busy) begin
                checks++;
                assert (busy_e === 1'b1) else begin
                    failures++; $error("FAIL busy_mid_frame observed=%b expected=1", busy_e);
                end
            end
        end
    endtask

    task automatic send_frame(input logic [2:0] word, input logic par, input int gap);
        for (int i = 0; i < 3; i++) begin
            send_bit(word[i]);
            if (gap > 0) idle(gap, 1'b1);
        end
        q_e.push_back({(^word) ^ par ^ 1'b0, word});
        q_o.push_back({(^word) ^ par ^ 1'b1, word});
        send_bit(par);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        w_valid = 1'b1;
        w = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        w_valid = 1'b0;
        w = 1'b0;
`ifdef PARITY_ERR_CNT_EN
        exp_cnt_e = 0;
        exp_cnt_o = 0;
`endif
    endtask

    initial begin
        int p0;
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        assert ({data_out_e, data_valid_e, parity_err_e, busy_e} === 6'b0) else begin
            failures++; $error("FAIL reset_even observed=%b expected=000000", {data_out_e, data_valid_e, parity_err_e, busy_e});
        end
        checks++;
        assert ({data_out_o, data_valid_o, parity_err_o, busy_o} === 6'b0) else begin
            failures++; $error("FAIL reset_odd observed=%b expected=000000", {data_out_o, data_valid_o, parity_err_o, busy_o});
        end
`ifdef PARITY_ERR_CNT_EN
        checks++;
        assert (err_count_e === 8'd0 && err_count_o === 2'd0) else begin
            failures++; $error("FAIL reset_errcnt observed=%0d/%0d expected=0/0", err_count_e, err_count_o);
        end
`endif

        // Good frame 1,0,1 parity 0
        send_frame(3'b101, 1'b0, 0);
        idle(3, 1'b0);
        checks++;
        assert (data_valid_e === 1'b0 && data_out_e === 3'b101) else begin
            failures++; $error("FAIL hold_after_pulse observed=%b/%b expected=0/101", data_valid_e, data_out_e);
        end

        // Bad frame 1,0,0 parity 0
        send_frame(3'b001, 1'b0, 0);
        idle(2, 1'b0);
        checks++;
        assert (parity_err_e === 1'b1) else begin
            failures++; $error("FAIL perr_held observed=%b expected=1", parity_err_e);
        end

        // Same good frame with 2 idle cycles between bits
        send_frame(3'b101, 1'b0, 2);
        idle(3, 1'b0);

        // Reset after two data bits, then fresh frame 0,1,1 parity 0
        p0 = pulses_e;
        send_bit(1'b1);
        send_bit(1'b1);
        idle(1, 1'b1);
        do_reset();
        checks++;
        assert (busy_e === 1'b0 && data_out_e === 3'b000 && pulses_e == p0) else begin
            failures++; $error("FAIL mid_reset observed=busy%b data%b pulses%0d expected=busy0 data000 pulses%0d", busy_e, data_out_e, pulses_e, p0);
        end
        send_frame(3'b110, 1'b0, 0);
        idle(3, 1'b0);
        checks++;
        assert (data_out_e === 3'b110 && parity_err_e === 1'b0) else begin
            failures++; $error("FAIL after_reset_frame observed=%b/%b expected=110/0", data_out_e, parity_err_e);
        end

        // Three back-to-back frames, w_valid held high
        times_e.delete();
        send_frame(3'b011, 1'b0, 0);
        send_frame(3'b100, 1'b0, 0);
        send_frame(3'b111, 1'b1, 0);
        idle(3, 1'b0);
        checks++;
        assert (times_e.size() == 3) else begin
            failures++; $error("FAIL b2b_pulse_count observed=%0d expected=3", times_e.size());
        end
        if (times_e.size() == 3) begin
            checks++;
            assert (times_e[1] - times_e[0] == 4 && times_e[2] - times_e[1] == 4) else begin
                failures++; $error("FAIL b2b_spacing observed=%0d,%0d expected=4,4", times_e[1] - times_e[0], times_e[2] - times_e[1]);
            end
        end

        // Five frames 1,1,0 parity 0: odd instance flags every one
        do_reset();
        for (int f = 0; f < 5; f++) send_frame(3'b011, 1'b0, 0);
        idle(4, 1'b0);
        checks++;
        assert (parity_err_o === 1'b1 && parity_err_e === 1'b0) else begin
            failures++; $error("FAIL odd_sense observed=%b/%b expected=1/0", parity_err_o, parity_err_e);
        end
`ifdef PARITY_ERR_CNT_EN
        checks++;
        assert (err_count_o === 2'd3) else begin
            failures++; $error("FAIL odd_saturate observed=%0d expected=3", err_count_o);
        end
`endif

        // Every pushed expectation must have been consumed by a pulse
        checks++;
        assert (q_e.size() == 0 && q_o.size() == 0) else begin
            failures++; $error("FAIL missing_pulses observed=%0d/%0d expected=0/0", q_e.size(), q_o.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
